// File: rtl/word_serializer.sv
// Wide-word to narrow-beat serializer with valid/ready on both sides.
// A finished word hands over to the next one on the same edge, so back-to-back words stream without gaps.
module word_serializer #(
    parameter int WORD_W    = 64,
    parameter int OUT_W     = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int BEATS = WORD_W / OUT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
    localparam logic FIRST_IS_LAST = (BEATS == 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    generate
        if (((WORD_W % OUT_W) != 0) || (OUT_W > WORD_W)) begin : g_bad_params
            $error("word_serializer: WORD_W must be a non-zero multiple of OUT_W");
        end
    endgenerate

    state_t            state_r, state_s;
    logic [WORD_W-1:0] shift_r, shift_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              last_r, last_s;
    logic              run_r;
    logic              in_ready_s;
    logic              load_s;

    // Acceptance: idle, or the last beat leaves this cycle; gated until the first edge after reset.
    always_comb begin
        in_ready_s = run_r & ((state_r == IDLE) | ((state_r == SEND) & out_ready & last_r));
        load_s     = in_valid & in_ready_s;
    end

    // Next-state and datapath update for the two-state serializer.
    always_comb begin
        state_s = state_r;
        shift_s = shift_r;
        cnt_s   = cnt_r;
        last_s  = last_r;
        case (state_r)
            IDLE: begin
                if (load_s) begin
                    state_s = SEND;
                    shift_s = in_data;
                    cnt_s   = {CNT_W{1'b0}};
                    last_s  = FIRST_IS_LAST;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (!out_ready) begin
                    state_s = SEND;
                end else if (!last_r) begin
                    if (MSB_FIRST != 0) begin
                        shift_s = shift_r << OUT_W;
                    end else begin
                        shift_s = shift_r >> OUT_W;
                    end
                    cnt_s  = cnt_r + CNT_W'(1);
                    last_s = ((cnt_r + CNT_W'(1)) == LAST_CNT);
                end else if (load_s) begin
                    shift_s = in_data;
                    cnt_s   = {CNT_W{1'b0}};
                    last_s  = FIRST_IS_LAST;
                end else begin
                    // Clearing the shifter keeps out_data at zero while idle.
                    state_s = IDLE;
                    shift_s = {WORD_W{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
                    last_s  = 1'b0;
                end
            end
            default: begin
                state_s = IDLE;
                shift_s = {WORD_W{1'b0}};
                cnt_s   = {CNT_W{1'b0}};
                last_s  = 1'b0;
            end
        endcase
    end

    // State, shifter, beat counter and the post-reset run flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            shift_r <= {WORD_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            last_r  <= 1'b0;
            run_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            shift_r <= shift_s;
            cnt_r   <= cnt_s;
            last_r  <= last_s;
            run_r   <= 1'b1;
        end
    end

    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign out_data = shift_r[WORD_W-1 -: OUT_W];
        end else begin : g_lsb
            assign out_data = shift_r[OUT_W-1:0];
        end
    endgenerate

    assign in_ready  = in_ready_s;
    assign out_valid = (state_r == SEND);
    assign busy      = (state_r == SEND);
    assign out_last  = last_r;

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: directed scenarios plus a randomized run
// checked against a queue-of-beats model.
module tb_word_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = 64'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;

    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [63:0] b_in_data = 64'd0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b0;
    logic [15:0] b_out_data;
    logic        b_out_last;
    logic        b_busy;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    word_serializer #(.WORD_W(64), .OUT_W(8), .MSB_FIRST(0)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    word_serializer #(.WORD_W(64), .OUT_W(16), .MSB_FIRST(1)) dut_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_last(b_out_last), .busy(b_busy)
    );

    // Beat i of a word, LSB-first, 8-bit beats.
    function automatic logic [7:0] beat8(input logic [63:0] w, input int i);
        return 8'(w >> (8 * i));
    endfunction

    // Beat i of a word, MSB-first, 16-bit beats.
    function automatic logic [15:0] beat16_msb(input logic [63:0] w, input int i);
        return 16'(w >> (64 - 16 * (i + 1)));
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            in_valid  = 1'($urandom());
            in_data   = {$urandom(), $urandom()};
            out_ready = 1'($urandom());
            #1;
            total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got=%0b exp=0", out_valid); else passed++;
            total++; if (out_data !== 8'h00) $display("FAIL rst_data got=%h exp=00", out_data); else passed++;
            total++; if (busy !== 1'b0) $display("FAIL rst_busy got=%0b exp=0", busy); else passed++;
            total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got=%0b exp=0", in_ready); else passed++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) $display("FAIL rel_in_ready got=%0b exp=1", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL rel_valid got=%0b exp=0", out_valid); else passed++;
    endtask

    task automatic test_single();
        logic [63:0] w;
        w = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        in_valid = 1'b1; in_data = w; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL single_ready got=%0b exp=1", in_ready); else passed++;
        @(negedge clk);
        in_valid = 1'b0; in_data = {$urandom(), $urandom()};
        for (int i = 0; i < 8; i++) begin
            total++; if (out_valid !== 1'b1) $display("FAIL single_valid beat=%0d got=%0b exp=1", i, out_valid); else passed++;
            total++; if (out_data !== beat8(w, i)) $display("FAIL single_data beat=%0d got=%h exp=%h", i, out_data, beat8(w, i)); else passed++;
            total++; if (out_last !== (i == 7)) $display("FAIL single_last beat=%0d got=%0b exp=%0b", i, out_last, (i == 7)); else passed++;
            total++; if (busy !== 1'b1) $display("FAIL single_busy beat=%0d got=%0b exp=1", i, busy); else passed++;
            @(negedge clk);
        end
        total++; if (out_valid !== 1'b0) $display("FAIL single_idle got=%0b exp=0", out_valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL single_idle_busy got=%0b exp=0", busy); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] w1, w2, w;
        w1 = {$urandom(), $urandom()};
        w2 = {$urandom(), $urandom()};
        @(negedge clk);
        in_valid = 1'b1; in_data = w1; out_ready = 1'b1;
        @(negedge clk);
        in_data = w2;
        for (int i = 0; i < 16; i++) begin
            w = (i < 8) ? w1 : w2;
            total++; if (out_valid !== 1'b1) $display("FAIL b2b_valid beat=%0d got=%0b exp=1", i, out_valid); else passed++;
            total++; if (out_data !== beat8(w, i % 8)) $display("FAIL b2b_data beat=%0d got=%h exp=%h", i, out_data, beat8(w, i % 8)); else passed++;
            total++; if (out_last !== ((i % 8) == 7)) $display("FAIL b2b_last beat=%0d got=%0b exp=%0b", i, out_last, ((i % 8) == 7)); else passed++;
            total++; if (in_ready !== ((i % 8) == 7)) $display("FAIL b2b_in_ready beat=%0d got=%0b exp=%0b", i, in_ready, ((i % 8) == 7)); else passed++;
            if (i == 8) in_valid = 1'b0;
            @(negedge clk);
        end
        total++; if (out_valid !== 1'b0) $display("FAIL b2b_idle got=%0b exp=0", out_valid); else passed++;
    endtask

    task automatic test_backpressure();
        logic [63:0] w;
        int idx;
        int stall;
        w = 64'h0123_4567_89AB_CDEF;
        idx = 0; stall = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = w; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 20 && idx < 8; c++) begin
            total++; if (out_valid !== 1'b1) $display("FAIL bp_valid cyc=%0d got=%0b exp=1", c, out_valid); else passed++;
            total++; if (out_data !== beat8(w, idx)) $display("FAIL bp_data cyc=%0d got=%h exp=%h", c, out_data, beat8(w, idx)); else passed++;
            total++; if (out_last !== (idx == 7)) $display("FAIL bp_last cyc=%0d got=%0b exp=%0b", c, out_last, (idx == 7)); else passed++;
            if (idx == 2 && stall < 3) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = 1'b1;
                idx++;
            end
            @(negedge clk);
        end
        total++; if (idx !== 8 || stall !== 3) $display("FAIL bp_count got=%0d/%0d exp=8/3", idx, stall); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL bp_idle got=%0b exp=0", out_valid); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [63:0] w, w2;
        w  = {$urandom(), $urandom()};
        w2 = 64'hFFEE_DDCC_BBAA_9988;
        @(negedge clk);
        in_valid = 1'b1; in_data = w; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (out_data !== beat8(w, i)) $display("FAIL rm_pre_data beat=%0d got=%h exp=%h", i, out_data, beat8(w, i)); else passed++;
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL rm_valid got=%0b exp=0", out_valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rm_busy got=%0b exp=0", busy); else passed++;
        total++; if (out_data !== 8'h00) $display("FAIL rm_data got=%h exp=00", out_data); else passed++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL rm_no_resume got=%0b exp=0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL rm_in_ready got=%0b exp=1", in_ready); else passed++;
        in_valid = 1'b1; in_data = w2;
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_data !== 8'h88 || out_valid !== 1'b1) $display("FAIL rm_first got=%h/%0b exp=88/1", out_data, out_valid); else passed++;
        @(negedge clk);
        total++; if (out_data !== 8'h99) $display("FAIL rm_second got=%h exp=99", out_data); else passed++;
        repeat (7) @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL rm_idle got=%0b exp=0", out_valid); else passed++;
    endtask

    task automatic test_msb16();
        logic [63:0] w;
        w = 64'h1111_2222_3333_4444;
        @(negedge clk);
        b_in_valid = 1'b1; b_in_data = w; b_out_ready = 1'b1;
        #1;
        total++; if (b_in_ready !== 1'b1) $display("FAIL msb_ready got=%0b exp=1", b_in_ready); else passed++;
        @(negedge clk);
        b_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (b_out_valid !== 1'b1 || b_busy !== 1'b1) $display("FAIL msb_valid beat=%0d got=%0b/%0b exp=1/1", i, b_out_valid, b_busy); else passed++;
            total++; if (b_out_data !== beat16_msb(w, i)) $display("FAIL msb_data beat=%0d got=%h exp=%h", i, b_out_data, beat16_msb(w, i)); else passed++;
            total++; if (b_out_last !== (i == 3)) $display("FAIL msb_last beat=%0d got=%0b exp=%0b", i, b_out_last, (i == 3)); else passed++;
            @(negedge clk);
        end
        total++; if (b_out_valid !== 1'b0) $display("FAIL msb_idle got=%0b exp=0", b_out_valid); else passed++;
    endtask

    task automatic test_random();
        logic [7:0] q_data[$];
        logic       q_last[$];
        logic       exp_valid, exp_ready, in_hs, out_hs;
        logic [63:0] w;
        in_hs = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (in_hs) in_valid = 1'b0;
            if (!in_valid && ($urandom_range(0, 99) < 60)) begin
                in_valid = 1'b1;
                in_data  = {$urandom(), $urandom()};
            end
            out_ready = ($urandom_range(0, 99) < 70);
            #1;
            exp_valid = (q_data.size() != 0);
            exp_ready = (q_data.size() == 0) || ((q_data.size() == 1) && out_ready);
            total++; if (out_valid !== exp_valid) $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", c, out_valid, exp_valid); else passed++;
            total++; if (busy !== exp_valid) $display("FAIL rnd_busy cyc=%0d got=%0b exp=%0b", c, busy, exp_valid); else passed++;
            total++; if (in_ready !== exp_ready) $display("FAIL rnd_in_ready cyc=%0d got=%0b exp=%0b", c, in_ready, exp_ready); else passed++;
            if (exp_valid) begin
                total++; if (out_data !== q_data[0]) $display("FAIL rnd_data cyc=%0d got=%h exp=%h", c, out_data, q_data[0]); else passed++;
                total++; if (out_last !== q_last[0]) $display("FAIL rnd_last cyc=%0d got=%0b exp=%0b", c, out_last, q_last[0]); else passed++;
            end
            in_hs  = in_valid & exp_ready;
            out_hs = exp_valid & out_ready;
            w      = in_data;
            @(posedge clk);
            if (out_hs) begin
                void'(q_data.pop_front());
                void'(q_last.pop_front());
            end
            if (in_hs) begin
                for (int i = 0; i < 8; i++) begin
                    q_data.push_back(beat8(w, i));
                    q_last.push_back(i == 7);
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_msb16();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
